// File: rtl/codec_uart_sequencer.sv
// Frame sequencer between a byte-wide UART and an encode/decode engine:
// collects an input frame, hands it to the engine, then paces the result bytes out to the transmitter.
module codec_uart_sequencer #(
   parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_000_000,
   parameter logic [15:0] GAP_CYCLES     = 16'd1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mode,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        eng_start,
   output logic        eng_mode,
   output logic [63:0] eng_buf_in,
   input  logic        eng_done,
   input  logic [63:0] eng_buf_out,
   output logic        tx_start,
   output logic [7:0]  tx_data,
   input  logic        tx_busy,
   output logic        busy,
   output logic        frame_done,
   output logic        timeout,
   output logic        overrun
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_COLLECT = 3'd1,
      S_RUN     = 3'd2,
      S_SEND    = 3'd3,
      S_GAP     = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [3:0]  idx_q, idx_d;
   logic [23:0] timer_q, timer_d;
   logic [15:0] gap_q, gap_d;
   logic        eng_start_q, eng_start_d;
   logic        eng_mode_q, eng_mode_d;
   logic [63:0] eng_buf_in_q, eng_buf_in_d;
   logic [63:0] out_buf_q, out_buf_d;
   logic        tx_start_q, tx_start_d;
   logic [7:0]  tx_data_q, tx_data_d;
   logic        busy_q, busy_d;
   logic        frame_done_q, frame_done_d;
   logic        timeout_q, timeout_d;
   logic        overrun_q, overrun_d;

   logic [3:0]  last_in;
   logic [3:0]  last_out;
   logic        timer_expired;
   logic        gap_expired;

   assign last_in       = eng_mode_q ? 4'd7 : 4'd3;
   assign last_out      = eng_mode_q ? 4'd3 : 4'd7;
   // Timer is reloaded to 1 on each byte, so it holds the idle-cycle count of the current cycle.
   assign timer_expired = ({1'b0, timer_q} + 25'd1) >= {1'b0, TIMEOUT_CYCLES};
   assign gap_expired   = ({1'b0, gap_q} + 17'd1) >= {1'b0, GAP_CYCLES};

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      idx_d        = idx_q;
      timer_d      = timer_q;
      gap_d        = gap_q;
      eng_start_d  = eng_start_q;
      eng_mode_d   = eng_mode_q;
      eng_buf_in_d = eng_buf_in_q;
      out_buf_d    = out_buf_q;
      tx_start_d   = 1'b0;
      tx_data_d    = tx_data_q;
      frame_done_d = 1'b0;
      timeout_d    = 1'b0;
      overrun_d    = overrun_q;

      case (state_q)
         S_IDLE: begin
            if (rx_valid) begin
               eng_mode_d   = mode;
               eng_buf_in_d = {rx_data, 56'd0};
               cnt_d        = 4'd1;
               timer_d      = 24'd1;
               state_d      = S_COLLECT;
            end
         end
         S_COLLECT: begin
            if (rx_valid) begin
               for (int k = 1; k < 8; k++) begin
                  if (cnt_q == 4'(k)) eng_buf_in_d[63-8*k -: 8] = rx_data;
               end
               cnt_d   = cnt_q + 4'd1;
               timer_d = 24'd1;
               if (cnt_q == last_in) begin
                  eng_start_d = 1'b1;
                  state_d     = S_RUN;
               end
            end else if (timer_expired) begin
               timeout_d = 1'b1;
               cnt_d     = 4'd0;
               timer_d   = 24'd0;
               state_d   = S_IDLE;
            end else begin
               timer_d = timer_q + 24'd1;
            end
         end
         S_RUN: begin
            if (eng_done) begin
               out_buf_d   = eng_buf_out;
               idx_d       = 4'd0;
               eng_start_d = 1'b0;
               state_d     = S_SEND;
            end
         end
         S_SEND: begin
            // Result bytes leave MSB-first by shifting the captured buffer.
            if (!tx_busy) begin
               tx_data_d  = out_buf_q[63:56];
               out_buf_d  = {out_buf_q[55:0], 8'd0};
               tx_start_d = 1'b1;
               gap_d      = 16'd0;
               state_d    = S_GAP;
            end
         end
         S_GAP: begin
            if (gap_expired) begin
               gap_d = 16'd0;
               if (idx_q == last_out) begin
                  frame_done_d = 1'b1;
                  idx_d        = 4'd0;
                  state_d      = S_IDLE;
               end else begin
                  idx_d   = idx_q + 4'd1;
                  state_d = S_SEND;
               end
            end else begin
               gap_d = gap_q + 16'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (rx_valid && (state_q == S_RUN || state_q == S_SEND || state_q == S_GAP))
         overrun_d = 1'b1;

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= 4'd0;
         idx_q        <= 4'd0;
         timer_q      <= 24'd0;
         gap_q        <= 16'd0;
         eng_start_q  <= 1'b0;
         eng_mode_q   <= 1'b0;
         eng_buf_in_q <= 64'd0;
         out_buf_q    <= 64'd0;
         tx_start_q   <= 1'b0;
         tx_data_q    <= 8'd0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         timeout_q    <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         timer_q      <= timer_d;
         gap_q        <= gap_d;
         eng_start_q  <= eng_start_d;
         eng_mode_q   <= eng_mode_d;
         eng_buf_in_q <= eng_buf_in_d;
         out_buf_q    <= out_buf_d;
         tx_start_q   <= tx_start_d;
         tx_data_q    <= tx_data_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
         timeout_q    <= timeout_d;
         overrun_q    <= overrun_d;
      end
   end

   assign eng_start  = eng_start_q;
   assign eng_mode   = eng_mode_q;
   assign eng_buf_in = eng_buf_in_q;
   assign tx_start   = tx_start_q;
   assign tx_data    = tx_data_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;
   assign timeout    = timeout_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_codec_uart_sequencer.sv
// Scoreboard bench for codec_uart_sequencer: directed frames push expected engine
// requests and TX bytes; negedge monitors pop and compare as the DUT presents them.
module tb_codec_uart_sequencer;

   localparam logic [23:0] TO_CYC  = 24'd100;
   localparam logic [15:0] GAP_CYC = 16'd8;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        mode = 1'b0;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = 8'd0;
   logic        eng_start;
   logic        eng_mode;
   logic [63:0] eng_buf_in;
   logic        eng_done = 1'b0;
   logic [63:0] eng_buf_out = 64'd0;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        tx_busy = 1'b0;
   logic        busy;
   logic        frame_done;
   logic        timeout;
   logic        overrun;

   codec_uart_sequencer #(.TIMEOUT_CYCLES(TO_CYC), .GAP_CYCLES(GAP_CYC)) dut (
      .clk(clk), .reset(reset), .mode(mode), .rx_valid(rx_valid), .rx_data(rx_data),
      .eng_start(eng_start), .eng_mode(eng_mode), .eng_buf_in(eng_buf_in),
      .eng_done(eng_done), .eng_buf_out(eng_buf_out), .tx_start(tx_start),
      .tx_data(tx_data), .tx_busy(tx_busy), .busy(busy), .frame_done(frame_done),
      .timeout(timeout), .overrun(overrun)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        m;
      logic [63:0] data;
   } eng_req_t;

   logic [7:0] exp_tx[$];
   eng_req_t   exp_eng[$];
   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int tx_seen = 0;
   int fd_cnt = 0;
   int to_cnt = 0;
   int last_tx = 0;
   bit have_last = 1'b0;
   logic eng_start_prev = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Monitors: compare whatever the DUT presents against the scoreboard queues.
   always @(negedge clk) begin
      if (!reset) begin
         if (tx_start) begin
            tx_seen++;
            if (exp_tx.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL tx_unexpected: got byte %h expected no tx_start", tx_data);
            end else begin
               chk("tx_data", 64'(tx_data), 64'(exp_tx.pop_front()));
            end
            if (have_last) chk("tx_gap_ok", 64'((cyc - last_tx) >= int'(GAP_CYC)), 64'd1);
            last_tx   = cyc;
            have_last = 1'b1;
         end
         if (eng_start && !eng_start_prev) begin
            if (exp_eng.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL eng_unexpected: got eng_start buf %h expected none", eng_buf_in);
            end else begin
               eng_req_t e;
               e = exp_eng.pop_front();
               chk("eng_mode", 64'(eng_mode), 64'(e.m));
               chk("eng_buf_in", eng_buf_in, e.data);
            end
         end
         if (frame_done) fd_cnt++;
         if (timeout) to_cnt++;
      end
      eng_start_prev = eng_start;
   end

   task automatic rx_byte(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      @(posedge clk);
      #1 rx_valid = 1'b0;
   endtask

   // Sends n bytes; mode is flipped after byte 0 to show it is ignored mid-frame.
   task automatic send_frame(input logic m, input logic [63:0] bytes, input int n);
      logic [63:0] b;
      b = bytes;
      mode = m;
      for (int i = 0; i < n; i++) begin
         rx_byte(b[63:56]);
         b = {b[55:0], 8'd0};
         if (i == 0) mode = ~m;
         if (i != n - 1) begin
            repeat (2) @(posedge clk);
            #1;
         end
      end
      chk("eng_start_after_last_byte", 64'(eng_start), 64'd1);
   endtask

   task automatic engine_reply(input logic [63:0] res);
      repeat (3) @(posedge clk);
      #1 chk("eng_start_held", 64'(eng_start), 64'd1);
      eng_done    = 1'b1;
      eng_buf_out = res;
      @(posedge clk);
      #1 eng_done = 1'b0;
      chk("eng_start_dropped", 64'(eng_start), 64'd0);
   endtask

   task automatic wait_frame_done(input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(negedge clk);
         if (frame_done) seen = 1'b1;
      end
      chk(name, 64'(seen), 64'd1);
      chk({name, "_idle"}, 64'(busy), 64'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic push_tx(input logic [63:0] res, input int n);
      logic [63:0] r;
      r = res;
      for (int i = 0; i < n; i++) begin
         exp_tx.push_back(r[63:56]);
         r = {r[55:0], 8'd0};
      end
   endtask

   initial begin
      int n;
      int stray;
      bit seen;

      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      chk("rst_flags", 64'({eng_start, eng_mode, tx_start, busy, frame_done, timeout, overrun}), 64'd0);
      chk("rst_tx_data", 64'(tx_data), 64'd0);
      chk("rst_eng_buf_in", eng_buf_in, 64'd0);

      // Encode frame; a stray eng_done while idle must be ignored.
      eng_done = 1'b1;
      @(posedge clk);
      #1 eng_done = 1'b0;
      chk("idle_eng_done_ignored", 64'(busy), 64'd0);
      exp_eng.push_back('{1'b0, 64'hA53CFF00_00000000});
      push_tx(64'h01234567_89ABCDEF, 8);
      send_frame(1'b0, 64'hA53CFF00_00000000, 4);
      chk("busy_in_run", 64'(busy), 64'd1);
      engine_reply(64'h01234567_89ABCDEF);
      wait_frame_done("enc_frame_done");

      // Decode frame: only the upper four result bytes are sent.
      exp_eng.push_back('{1'b1, 64'h11223344_55667788});
      push_tx(64'hDEADBEEF_FFFFFFFF, 4);
      send_frame(1'b1, 64'h11223344_55667788, 8);
      engine_reply(64'hDEADBEEF_FFFFFFFF);
      wait_frame_done("dec_frame_done");
      chk("overrun_clear", 64'(overrun), 64'd0);

      // Partial frame then silence: timeout exactly TO_CYC cycles after the 2nd byte.
      mode = 1'b0;
      rx_byte(8'h77);
      repeat (2) @(posedge clk);
      #1 rx_byte(8'h66);
      n = 0;
      seen = 1'b0;
      while (!seen && n < 300) begin
         @(negedge clk);
         n++;
         if (timeout) seen = 1'b1;
      end
      chk("timeout_latency", 64'(n), 64'(TO_CYC));
      chk("timeout_idle", 64'(busy), 64'd0);
      @(posedge clk);
      #1;

      // Fresh frame; byte 1 lands in the timer's expiry cycle and must be kept.
      mode = 1'b0;
      exp_eng.push_back('{1'b0, 64'hC1C2C3C4_00000000});
      push_tx(64'h0F1E2D3C_4B5A6978, 8);
      rx_byte(8'hC1);
      repeat (98) @(posedge clk);
      #1 rx_byte(8'hC2);
      rx_byte(8'hC3);
      rx_byte(8'hC4);
      chk("fresh_eng_start", 64'(eng_start), 64'd1);
      tx_busy = 1'b1;
      engine_reply(64'h0F1E2D3C_4B5A6978);
      stray = 0;
      for (int i = 0; i < 50; i++) begin
         if (i == 10) begin
            rx_valid = 1'b1;
            rx_data  = 8'h99;
         end
         @(posedge clk);
         #1 rx_valid = 1'b0;
         if (tx_start) stray++;
      end
      chk("tx_held_while_busy", 64'(stray), 64'd0);
      chk("overrun_set", 64'(overrun), 64'd1);
      tx_busy = 1'b0;
      wait_frame_done("fresh_frame_done");
      chk("overrun_sticky", 64'(overrun), 64'd1);

      // Reset during GAP after the 3rd output byte.
      exp_eng.push_back('{1'b0, 64'h10203040_00000000});
      push_tx(64'hA1B2C3D4_E5F60718, 3);
      send_frame(1'b0, 64'h10203040_00000000, 4);
      engine_reply(64'hA1B2C3D4_E5F60718);
      n = tx_seen + 3;
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         if (tx_seen >= n) seen = 1'b1;
      end
      chk("third_tx_seen", 64'(seen), 64'd1);
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      chk("gap_rst_flags", 64'({eng_start, eng_mode, tx_start, busy, frame_done, timeout, overrun}), 64'd0);
      chk("gap_rst_tx_data", 64'(tx_data), 64'd0);
      chk("gap_rst_eng_buf_in", eng_buf_in, 64'd0);
      repeat (40) @(posedge clk);
      #1;

      chk("tx_queue_drained", 64'(exp_tx.size()), 64'd0);
      chk("eng_queue_drained", 64'(exp_eng.size()), 64'd0);
      chk("frame_done_count", 64'(fd_cnt), 64'd3);
      chk("timeout_count", 64'(to_cnt), 64'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no completion expected $finish before time limit");
      $fatal(1, "watchdog");
   end

endmodule
